// File: rtl/ram_burst_if.sv
// ram_burst_if: command, write-data, read-data and RAM strobe signals of the burst controller
interface ram_burst_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
);
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy, done;
  logic              m_cen, m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din, m_dout;
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, m_dout,
    output req_ready, wr_ready, rd_valid, rd_data, busy, done, m_cen, m_wen, m_addr, m_din
  );
  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, m_dout,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, done, m_cen, m_wen, m_addr, m_din
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst read/write controller for a single-port RAM with 1-cycle read latency and 2-entry read FIFO
module ram_burst_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
) (
  input logic       clk,
  input logic       reset_n,
  ram_burst_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] cur;
  logic [LEN_W:0]    beats;
  logic              inflight, done_q;
  logic [1:0]        count;
  logic [DATA_W-1:0] f0, f1;
  logic              wr_hs, issue, pop, last, drained;
  assign wr_hs   = reset_n && state == WRITE && bus.wr_valid;
  assign pop     = reset_n && count != 2'd0 && bus.rd_ready;
  // issue only when the returning word is guaranteed a FIFO slot
  assign issue   = reset_n && state == READ && ({1'b0, count} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
  assign last    = beats == (LEN_W+1)'(1);
  assign drained = state == DRAIN && !inflight && count == 2'd0;
  always_comb begin
    state_n = (state == IDLE && bus.req_valid) ? (bus.req_write ? WRITE : READ) :
              (wr_hs && last)                  ? IDLE :
              (issue && last)                  ? DRAIN :
              drained                          ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur      <= '0;
      beats    <= '0;
      inflight <= 1'b0;
      count    <= 2'd0;
      done_q   <= 1'b0;
      f0       <= '0;
      f1       <= '0;
    end else begin
      state    <= state_n;
      done_q   <= (wr_hs && last) || drained;
      inflight <= issue;
      if (state == IDLE && bus.req_valid) begin
        cur   <= bus.req_addr;
        beats <= {1'b0, bus.req_len} + (LEN_W+1)'(1);
      end else if (wr_hs || issue) begin
        cur   <= cur + ADDR_W'(1);
        beats <= beats - (LEN_W+1)'(1);
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
      f0    <= pop ? (count == 2'd2 ? f1 : bus.m_dout) : (inflight && count == 2'd0) ? bus.m_dout : f0;
      f1    <= (inflight && (pop ? count == 2'd2 : count == 2'd1)) ? bus.m_dout : f1;
    end
  end
  assign bus.req_ready = reset_n && state == IDLE;
  assign bus.wr_ready  = reset_n && state == WRITE;
  assign bus.rd_valid  = reset_n && count != 2'd0;
  assign bus.rd_data   = reset_n ? f0 : '0;
  assign bus.busy      = reset_n && state != IDLE;
  assign bus.done      = reset_n && done_q;
  assign bus.m_cen     = wr_hs || issue;
  assign bus.m_wen     = wr_hs;
  assign bus.m_addr    = (wr_hs || issue) ? cur : '0;
  assign bus.m_din     = wr_hs ? bus.wr_data : '0;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed and random bursts checked against a word-array reference of RAM contents
module tb_ram_burst_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ram [32];
  logic [31:0] ref_mem [32];
  logic [31:0] wd [8];
  ram_burst_if #(.ADDR_W(5), .DATA_W(32), .LEN_W(3)) bus ();
  ram_burst_ctrl #(.ADDR_W(5), .DATA_W(32), .LEN_W(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.m_cen && bus.m_wen) ram[bus.m_addr] <= bus.m_din;
    if (bus.m_cen && !bus.m_wen) bus.m_dout <= ram[bus.m_addr];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!bus.m_cen) chk("quiet_strobes", {bus.m_wen, bus.m_addr, bus.m_din}, 64'd0);
  task automatic do_write(input logic [4:0] a, input int len, input int gap);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_len = 3'(len);
    @(negedge clk);
    chk("wr_req_ready", bus.req_ready, 1);
    step;
    bus.req_valid = 1'b0; bus.req_addr = 5'($urandom);
    for (int i = 0; i <= len; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap_state", {bus.wr_ready, bus.m_cen}, 2'b10);
        step;
      end
      bus.wr_valid = 1'b1; bus.wr_data = wd[i];
      @(negedge clk);
      chk("wr_busy", {bus.req_ready, bus.wr_ready, bus.busy}, 3'b011);
      chk("wr_strobe", {bus.m_cen, bus.m_wen, bus.m_addr, bus.m_din}, {2'b11, 5'(a + 5'(i)), wd[i]});
      step;
      bus.wr_valid = 1'b0;
    end
    @(negedge clk);
    chk("wr_done", {bus.done, bus.busy, bus.req_ready, bus.wr_ready}, 4'b1010);
    for (int i = 0; i <= len; i++) ref_mem[5'(a + 5'(i))] = wd[i];
    step;
    @(negedge clk);
    chk("wr_done_pulse", bus.done, 0);
    step;
  endtask
  task automatic do_read(input logic [4:0] a, input int len, input int mode);
    int n = 0, issued = 0, cyc = 1;
    logic seen_done = 1'b0, held = 1'b0;
    logic [31:0] hd = '0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_len = 3'(len);
    @(negedge clk);
    chk("rd_req_ready", bus.req_ready, 1);
    step;
    bus.req_valid = 1'b0;
    while (!seen_done && cyc < 100) begin
      bus.rd_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 <= 1) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (held) chk("rd_hold", {bus.rd_valid, bus.rd_data}, {1'b1, hd});
      if (bus.m_cen) begin
        chk("rd_strobe", {bus.m_wen, bus.m_addr}, {1'b0, 5'(a + 5'(issued))});
        issued++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk("rd_data", bus.rd_data, ref_mem[5'(a + 5'(n))]);
        if (mode == 0) chk("rd_cycle", cyc, 3 + n);
        n++;
      end
      chk("rd_ahead", issued - n <= 2, 1);
      held = bus.rd_valid && !bus.rd_ready;
      hd = bus.rd_data;
      if (bus.done) begin
        seen_done = 1'b1;
        chk("rd_done_state", {bus.rd_valid, bus.busy, bus.req_ready}, 3'b001);
        chk("rd_issued", issued, len + 1);
      end else chk("rd_busy", {bus.busy, bus.req_ready}, 2'b10);
      step;
      cyc++;
    end
    chk("rd_complete", {seen_done, 32'(n)}, {1'b1, 32'(len + 1)});
    bus.rd_ready = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    {bus.req_valid, bus.req_write, bus.req_addr, bus.req_len, bus.wr_valid, bus.wr_data, bus.rd_ready} = '0;
    step;
    @(negedge clk);
    chk("reset_outputs", {bus.req_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done,
                          bus.m_cen, bus.m_wen, bus.m_addr, bus.m_din}, 64'd0);
    step;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {bus.req_ready, bus.busy, bus.done, bus.rd_valid}, 4'b1000);
    step;
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    do_write(5'd30, 3, 0);
    do_read(5'd30, 3, 0);
    for (int i = 0; i < 8; i++) wd[i] = $urandom;
    do_write(5'd12, 7, 0);
    do_read(5'd12, 7, 1);
    wd[0] = 32'hDEADBEEF;
    do_write(5'd5, 0, 0);
    do_read(5'd5, 0, 0);
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    do_write(5'd20, 3, 2);
    do_read(5'd20, 3, 2);
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 5'd8; bus.req_len = 3'd3;
    step;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = wd[i];
      step;
    end
    reset_n = 1'b0; bus.wr_data = wd[2];
    @(negedge clk);
    chk("midburst_reset", {bus.req_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done,
                           bus.m_cen, bus.m_wen, bus.m_addr, bus.m_din}, 64'd0);
    step;
    reset_n = 1'b1; bus.wr_valid = 1'b0;
    ref_mem[8] = wd[0];
    ref_mem[9] = wd[1];
    do_read(5'd8, 3, 0);
    for (int k = 0; k < 6; k++) begin
      logic [4:0] a;
      int len;
      a = 5'($urandom);
      len = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) wd[i] = $urandom;
      do_write(a, len, $urandom_range(0, 2));
      do_read(5'($urandom_range(0, 31)), $urandom_range(0, 7), 2);
      do_read(a, len, 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
